// File: rtl/rv_pkg.sv
// Shared definitions for the instruction encoder: fixed RV64I opcodes,
// descriptor kinds and the load-session FSM states.
package rv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_R   = 2'b00,
        KIND_LD  = 2'b01,
        KIND_SD  = 2'b10,
        KIND_BEQ = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Descriptor stream in, instruction-memory write port out.
// The encoder sits on the slave side; the program source drives the master side.
interface rv_instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [12:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
               in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
               in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv_encode_word.sv
// Combinational descriptor-to-instruction encoder. With RV_ENC_CHECK_EN
// defined, misaligned beq offsets and unknown R-type funct7 values are flagged.
module rv_encode_word
    import rv_pkg::*;
(
    input  kind_e       kind,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word = '0;
        case (kind)
            KIND_R:   word = {funct7, rs2, rs1, funct3, rd, OP_RTYPE};
            KIND_LD:  word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            KIND_SD:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            KIND_BEQ: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                              imm[4:1], imm[11], OP_BRANCH};
            default:  word = '0;
        endcase
    end

`ifdef RV_ENC_CHECK_EN
    always_comb begin
        legal = 1'b1;
        if (kind == KIND_BEQ && imm[0])
            legal = 1'b0;
        if (kind == KIND_R && funct7 != 7'b0000000 && funct7 != 7'b0100000)
            legal = 1'b0;
    end
`else
    assign legal = 1'b1;
`endif

endmodule

// File: rtl/rv_instr_encoder.sv
// Loads encoded instruction words into instruction memory from START_ADDR.
// Optional descriptor legality checking is enabled by defining RV_ENC_CHECK_EN.
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    rv_instr_encoder_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     count,
    output logic                err
);

    localparam logic [ADDR_W:0] START_PTR = (ADDR_W+1)'(START_ADDR);
    localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W+1)'((1 << ADDR_W) - 1);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              mem_we_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        in_ready;
    logic        accept;
    logic        write_acc;
    logic        last_slot;
    logic        overflow;

    rv_encode_word u_encode (
        .kind   (kind_e'(bus.in_kind)),
        .funct3 (bus.in_funct3),
        .funct7 (bus.in_funct7),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .imm    (bus.in_imm),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    // wr_ptr_q carries one extra bit so a full memory is seen as "wrapped"
    assign in_ready  = (state_q == ST_RUN) && !wr_ptr_q[ADDR_W];
    assign accept    = bus.in_valid && in_ready;
    assign write_acc = accept && enc_legal;
    assign last_slot = (wr_ptr_q == LAST_PTR);
    assign overflow  = write_acc && last_slot && !bus.in_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && (bus.in_last || (write_acc && last_slot)))
                          state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= START_PTR;
            mem_addr_q  <= START_PTR[ADDR_W-1:0];
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= write_acc;
            if (write_acc) begin
                mem_wdata_q <= enc_word;
                mem_addr_q  <= wr_ptr_q[ADDR_W-1:0];
                wr_ptr_q    <= wr_ptr_q + PTR_ONE;
            end else if (mem_we_q && !wr_ptr_q[ADDR_W]) begin
                // after a write, advance the visible address but never wrap it
                mem_addr_q <= wr_ptr_q[ADDR_W-1:0];
            end
            if (mem_we_q)
                count_q <= count_q + PTR_ONE;
            if (overflow || (accept && !enc_legal))
                err_q <= 1'b1;
            if (state_q == ST_IDLE && start) begin
                wr_ptr_q   <= START_PTR;
                mem_addr_q <= START_PTR[ADDR_W-1:0];
                count_q    <= '0;
                err_q      <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done          = (state_q == ST_DONE);
    assign count         = count_q;
    assign err           = err_q;

endmodule
